// File: rtl/encap_pkg.sv
// Shared encapsulator definitions: encap mode encodings, config2 field layout
// and a small helper for zero-width AXIS sideband parameters.
package encap_pkg;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'd0,
        MODE_MAC   = 3'd1,
        MODE_IP4   = 3'd2,
        MODE_UDP   = 3'd3,
        MODE_NVGRE = 3'd4,
        MODE_VXLAN = 3'd5
    } encap_mode_t;

    localparam int CFG2_WIDTH = 291;
    localparam int NUM_WORDS  = 10;

    // Field order MSB..LSB; total width must equal CFG2_WIDTH.
    typedef struct packed {
        logic [23:0] vsid;
        logic [47:0] eth_dst;
        logic [47:0] eth_src;
        logic [31:0] vlan_tag;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] ip_id;
        logic [7:0]  ip_ttl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] udp_sport;
        logic [15:0] udp_dport;
        logic [7:0]  rsvd;
        logic [2:0]  mode_2;
    } config2_t;

    // A zero-width tid/tdest still needs one index bit.
    function automatic int eff_width(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/encap_inflight_tracker.sv
// Per-ID packet-in-progress flags plus the start-of-packet gate that lets the
// commit sequencer hold back new packets for one ID while leaving others alone.
module encap_inflight_tracker #(
    parameter  int ID_W    = 2,
    localparam int NUM_IDS = 2 ** ID_W
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               hold_en,
    input  logic [ID_W-1:0]    hold_id,
    input  logic [ID_W-1:0]    axis_tid,
    input  logic               axis_tlast,
    input  logic               up_tvalid,
    output logic               up_tready,
    output logic               dn_tvalid,
    input  logic               dn_tready,
    output logic [NUM_IDS-1:0] inflight
);

    logic sop;
    logic block;
    logic beat;

    // Only a beat that would open a new packet on the held ID is stalled.
    assign sop       = !inflight[axis_tid];
    assign block     = hold_en && (hold_id == axis_tid) && sop;
    assign dn_tvalid = up_tvalid && !block;
    assign up_tready = dn_tready && !block;
    assign beat      = dn_tvalid && dn_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inflight <= '0;
        end else if (beat) begin
            inflight[axis_tid] <= !axis_tlast;
        end
    end

endmodule

// File: rtl/encap_cfg_ctrl.sv
// Per-flow configuration tables with a staged shadow buffer; commits land only
// once the target ID is between packets so no header is built from mixed config.
module encap_cfg_ctrl
    import encap_pkg::*;
#(
    parameter  int AXIS_ID_WIDTH   = 2,
    parameter  int AXIS_DEST_WIDTH = 0,
    parameter  int CFG2_WIDTH      = 291,
    localparam int EFF_ID          = eff_width(AXIS_ID_WIDTH),
    localparam int EFF_DEST        = eff_width(AXIS_DEST_WIDTH),
    localparam int ENTRY_W         = EFF_ID + EFF_DEST
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ENTRY_W-1:0]    cfg_wr_entry,
    input  logic [3:0]            cfg_wr_word,
    input  logic [31:0]           cfg_wr_data,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic                  cfg_commit_valid,
    output logic                  cfg_commit_ready,
    input  logic                  up_tvalid,
    output logic                  up_tready,
    output logic                  dn_tvalid,
    input  logic                  dn_tready,
    input  logic [EFF_ID-1:0]     axis_tid,
    input  logic                  axis_tlast,
    input  logic [EFF_ID-1:0]     encap_config1_sel,
    output logic [2:0]            encap_config1_regs,
    input  logic [ENTRY_W-1:0]    encap_config2_sel,
    output logic [CFG2_WIDTH-1:0] encap_config2_regs
);

    localparam int NUM_IDS     = 2 ** EFF_ID;
    localparam int NUM_ENTRIES = 2 ** ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ENTRY_W-1:0]      tgt;
    logic [EFF_ID-1:0]       tgt_id;
    logic                    hold_en;
    logic                    wr_fire;
    logic [NUM_IDS-1:0]      inflight;
    logic [CFG2_WIDTH-1:0]   shadow_cfg2;
    logic [2:0]              shadow_mode;
    config2_t                table2 [NUM_ENTRIES];
    encap_mode_t             table1 [NUM_IDS];

    assign tgt_id  = tgt[ENTRY_W-1 -: EFF_ID];
    assign wr_fire = cfg_wr_valid && cfg_wr_ready;

    // Only the bits that reach a table are kept: words 0..8 whole, word 9 split
    // into the config2 tail [2:0] and mode_1 [6:4]; words 10..15 are swallowed.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            shadow_cfg2 <= '0;
            shadow_mode <= '0;
        end else if (wr_fire) begin
            for (int w = 0; w < NUM_WORDS - 1; w++) begin
                if (cfg_wr_word == 4'(w)) begin
                    shadow_cfg2[32*w +: 32] <= cfg_wr_data;
                end
            end
            if (cfg_wr_word == 4'(NUM_WORDS - 1)) begin
                shadow_cfg2[288 +: 3] <= cfg_wr_data[2:0];
                shadow_mode           <= cfg_wr_data[6:4];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cfg_commit_valid) begin
                tgt <= cfg_wr_entry;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        cfg_wr_ready     = 1'b0;
        cfg_commit_ready = 1'b0;
        hold_en          = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cfg_wr_ready = 1'b1;
                if (cfg_commit_valid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                hold_en = 1'b1;
                if (!inflight[tgt_id]) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cfg_commit_ready = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                table2[i] <= '0;
            end
            for (int i = 0; i < NUM_IDS; i++) begin
                table1[i] <= MODE_NONE;
            end
        end else if (state == ST_APPLY) begin
            table2[tgt]    <= config2_t'(shadow_cfg2);
            table1[tgt_id] <= encap_mode_t'(shadow_mode);
        end
    end

    assign encap_config1_regs = table1[encap_config1_sel];
    assign encap_config2_regs = table2[encap_config2_sel];

    encap_inflight_tracker #(
        .ID_W (EFF_ID)
    ) u_tracker (
        .aclk       (aclk),
        .areset     (areset),
        .hold_en    (hold_en),
        .hold_id    (tgt_id),
        .axis_tid   (axis_tid),
        .axis_tlast (axis_tlast),
        .up_tvalid  (up_tvalid),
        .up_tready  (up_tready),
        .dn_tvalid  (dn_tvalid),
        .dn_tready  (dn_tready),
        .inflight   (inflight)
    );

endmodule

// File: tb/tb_encap_cfg_ctrl.sv
// Scoreboard bench for encap_cfg_ctrl: stimulus queues expected values, a
// negedge monitor compares lookups/handshakes and commit pulses against them.
module tb_encap_cfg_ctrl;

    localparam int K_CFG1   = 0;
    localparam int K_CFG2   = 1;
    localparam int K_WRRDY  = 2;
    localparam int K_DNVLD  = 3;
    localparam int K_UPRDY  = 4;
    localparam int K_CMTRDY = 5;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [2:0]   cfg_wr_entry = '0;
    logic [3:0]   cfg_wr_word = '0;
    logic [31:0]  cfg_wr_data = '0;
    logic         cfg_wr_valid = 1'b0;
    logic         cfg_wr_ready;
    logic         cfg_commit_valid = 1'b0;
    logic         cfg_commit_ready;
    logic         up_tvalid = 1'b0;
    logic         up_tready;
    logic         dn_tvalid;
    logic         dn_tready = 1'b1;
    logic [1:0]   axis_tid = '0;
    logic         axis_tlast = 1'b0;
    logic [1:0]   encap_config1_sel = '0;
    logic [2:0]   encap_config1_regs;
    logic [2:0]   encap_config2_sel = '0;
    logic [290:0] encap_config2_regs;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    string        name_q[$];
    int           kind_q[$];
    logic [290:0] exp_q[$];
    int           pulse_q[$];
    logic [31:0]  mwords[10];

    encap_cfg_ctrl dut (
        .aclk               (aclk),
        .areset             (areset),
        .cfg_wr_entry       (cfg_wr_entry),
        .cfg_wr_word        (cfg_wr_word),
        .cfg_wr_data        (cfg_wr_data),
        .cfg_wr_valid       (cfg_wr_valid),
        .cfg_wr_ready       (cfg_wr_ready),
        .cfg_commit_valid   (cfg_commit_valid),
        .cfg_commit_ready   (cfg_commit_ready),
        .up_tvalid          (up_tvalid),
        .up_tready          (up_tready),
        .dn_tvalid          (dn_tvalid),
        .dn_tready          (dn_tready),
        .axis_tid           (axis_tid),
        .axis_tlast         (axis_tlast),
        .encap_config1_sel  (encap_config1_sel),
        .encap_config1_regs (encap_config1_regs),
        .encap_config2_sel  (encap_config2_sel),
        .encap_config2_regs (encap_config2_regs)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle <= cycle + 1;

    // Monitor: drains queued checks and matches each commit pulse to its expected cycle.
    always @(negedge aclk) begin
        logic [290:0] act;
        logic [290:0] expv;
        string        nm;
        int           k;
        int           ec;
        while (kind_q.size() > 0) begin
            k    = kind_q.pop_front();
            nm   = name_q.pop_front();
            expv = exp_q.pop_front();
            case (k)
                K_CFG1:  act = {288'd0, encap_config1_regs};
                K_CFG2:  act = encap_config2_regs;
                K_WRRDY: act = {290'd0, cfg_wr_ready};
                K_DNVLD: act = {290'd0, dn_tvalid};
                K_UPRDY: act = {290'd0, up_tready};
                default: act = {290'd0, cfg_commit_ready};
            endcase
            compared++;
            if (act !== expv) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h expected %h", nm, act, expv);
            end
        end
        if (cfg_commit_ready === 1'b1) begin
            compared++;
            if (pulse_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL commit_pulse: got pulse at cycle %0d expected none", cycle);
            end else begin
                ec = pulse_q.pop_front();
                if (ec != cycle) begin
                    mismatched++;
                    $display("[TB] FAIL commit_pulse: got cycle %0d expected cycle %0d", cycle, ec);
                end
            end
        end
    end

    function automatic logic [290:0] cfg2_of();
        logic [290:0] r;
        r = '0;
        for (int w = 0; w < 9; w++) r[32*w +: 32] = mwords[w];
        r[290:288] = mwords[9][2:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_output(input int kind, input string nm, input logic [290:0] expv);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        exp_q.push_back(expv);
    endtask

    task automatic write_word(input logic [3:0] w, input logic [31:0] d);
        cfg_wr_valid = 1'b1;
        cfg_wr_word  = w;
        cfg_wr_data  = d;
        tick();
        cfg_wr_valid = 1'b0;
        if (w < 10) mwords[w] = d;
    endtask

    task automatic commit(input logic [2:0] entry, output int p);
        cfg_wr_entry     = entry;
        cfg_commit_valid = 1'b1;
        tick();
        p = cycle;
        cfg_commit_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] tid, input logic last, output int t);
        up_tvalid  = 1'b1;
        axis_tid   = tid;
        axis_tlast = last;
        check_output(K_DNVLD, "beat_dn_tvalid", 291'd1);
        tick();
        t = cycle;
        up_tvalid  = 1'b0;
        axis_tlast = 1'b0;
    endtask

    task automatic check_tables(input string nm, input logic [1:0] s1, input logic [2:0] e1,
                                input logic [2:0] s2, input logic [290:0] e2);
        encap_config1_sel = s1;
        encap_config2_sel = s2;
        check_output(K_CFG1, {nm, "_cfg1"}, {288'd0, e1});
        check_output(K_CFG2, {nm, "_cfg2"}, e2);
        tick();
    endtask

    initial begin
        int p;
        int t;
        for (int w = 0; w < 10; w++) mwords[w] = '0;

        // 1: reset state
        repeat (3) tick();
        areset = 1'b0;
        check_output(K_WRRDY, "reset_wr_ready", 291'd1);
        check_output(K_CMTRDY, "reset_commit_ready", 291'd0);
        for (int i = 0; i < 8; i++) check_tables("reset", 2'(i), 3'd0, 3'(i), '0);

        // 2: stage full entry, commit entry 1 on an idle bus
        for (int w = 0; w < 10; w++) write_word(4'(w), 32'hA5A5_0000 + 32'(w));
        commit(3'd1, p);
        pulse_q.push_back(p + 1);
        tick();
        tick();
        check_tables("idle_commit_e1", 2'd0, 3'd0, 3'd1, cfg2_of());
        check_tables("idle_commit_e0", 2'd0, 3'd0, 3'd0, '0);

        // 3/4: commit {1,0} while a tid=1 packet is in flight
        write_word(4'd9, 32'h0000_0053);
        send_beat(2'd1, 1'b0, t);
        commit(3'd2, p);
        check_output(K_WRRDY, "drain_wr_ready", 291'd0);
        check_tables("drain_unchanged", 2'd1, 3'd0, 3'd2, '0);
        axis_tid   = 2'd2;
        axis_tlast = 1'b1;
        up_tvalid  = 1'b1;
        check_output(K_UPRDY, "drain_other_id_up_tready", 291'd1);
        send_beat(2'd2, 1'b1, t);
        send_beat(2'd1, 1'b0, t);
        send_beat(2'd1, 1'b0, t);
        check_tables("drain_still_unchanged", 2'd1, 3'd0, 3'd2, '0);
        send_beat(2'd1, 1'b1, t);
        pulse_q.push_back(t + 1);
        up_tvalid  = 1'b1;
        axis_tid   = 2'd1;
        axis_tlast = 1'b0;
        check_output(K_DNVLD, "drain_sop_dn_tvalid", 291'd0);
        check_output(K_UPRDY, "drain_sop_up_tready", 291'd0);
        tick();
        up_tvalid = 1'b0;
        tick();
        check_tables("drain_applied", 2'd1, 3'd5, 3'd2, cfg2_of());
        check_tables("drain_neighbour", 2'd1, 3'd5, 3'd3, '0);
        up_tvalid = 1'b1;
        check_output(K_DNVLD, "idle_sop_dn_tvalid", 291'd1);
        tick();
        up_tvalid = 1'b0;
        send_beat(2'd1, 1'b1, t);

        // 5: single-beat packet leaves no in-flight state
        send_beat(2'd3, 1'b1, t);
        commit(3'd7, p);
        pulse_q.push_back(p + 1);
        tick();
        tick();
        check_tables("single_beat", 2'd3, 3'd5, 3'd7, cfg2_of());

        // write and commit in the same cycle: commit sees the new word
        cfg_wr_valid     = 1'b1;
        cfg_wr_word      = 4'd0;
        cfg_wr_data      = 32'h1234_5678;
        cfg_wr_entry     = 3'd0;
        cfg_commit_valid = 1'b1;
        tick();
        p = cycle;
        cfg_wr_valid     = 1'b0;
        cfg_commit_valid = 1'b0;
        mwords[0] = 32'h1234_5678;
        pulse_q.push_back(p + 1);
        tick();
        tick();
        check_tables("same_cycle", 2'd0, 3'd5, 3'd0, cfg2_of());

        // out-of-range word is dropped
        write_word(4'd12, 32'hFFFF_FFFF);
        commit(3'd4, p);
        pulse_q.push_back(p + 1);
        tick();
        tick();
        check_tables("oob_word", 2'd2, 3'd5, 3'd4, cfg2_of());

        // 6: reset in DRAIN abandons the commit
        send_beat(2'd0, 1'b0, t);
        commit(3'd1, p);
        tick();
        areset = 1'b1;
        for (int w = 0; w < 10; w++) mwords[w] = '0;
        tick();
        tick();
        areset = 1'b0;
        check_output(K_WRRDY, "post_reset_wr_ready", 291'd1);
        check_output(K_CMTRDY, "post_reset_commit_ready", 291'd0);
        check_tables("post_reset_e1", 2'd1, 3'd0, 3'd1, '0);
        check_tables("post_reset_e7", 2'd3, 3'd0, 3'd7, '0);
        repeat (5) tick();

        while (pulse_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL commit_pulse: got none expected cycle %0d", pulse_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
